// File: rtl/nvram_sd_sync.sv
// Sector-granular load/save of battery-backed cart NVRAM over the hps_io sd port.
// Define NVRAM_AUTOSAVE_EN to add the save-on-OSD-open trigger.
module nvram_sd_sync #(
    parameter int SECT_W = 6,
    parameter int LBA_W  = 32
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              download,
    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    input  logic              load_req,
    input  logic              save_req,
    input  logic              osd_open,
    input  logic              autosave,
    input  logic              nv_we,
    input  logic [SECT_W+8:0] nv_addr,
    input  logic              sd_ack,
    output logic [LBA_W-1:0]  sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    output logic              ena,
    output logic              busy,
    output logic              loading,
    output logic              pending
);
    localparam int NSECT = 1 << SECT_W;
    localparam logic [SECT_W:0] ONE = (SECT_W+1)'(1);

    typedef enum logic [1:0] {IDLE, SCAN, REQ, ACKH} state_t;

    // Sector count of the image, rounded up and saturated at the NVRAM size.
    function automatic logic [SECT_W:0] clip_nsec(input logic [63:0] size);
        logic [55:0] whole;
        whole = {1'b0, size[63:9]} + 56'(size[8:0] != 9'd0);
        if (whole > 56'(NSECT))
            return (SECT_W+1)'(NSECT);
        return whole[SECT_W:0];
    endfunction

    // Returns {found, index} of the lowest set bit of map at or above from.
    function automatic logic [SECT_W:0] find_dirty(input logic [NSECT-1:0] map,
                                                   input logic [SECT_W-1:0] from);
        logic [SECT_W:0] r;
        r = '0;
        for (int i = NSECT - 1; i >= 0; i--) begin
            if (map[i] && (i >= int'(from)))
                r = {1'b1, SECT_W'(i)};
        end
        return r;
    endfunction

    state_t           state_q;
    logic [SECT_W-1:0] cursor_q;
    logic [SECT_W-1:0] lba_q;
    logic             rd_q, wr_q, ena_q, loading_q, ack_seen_q;
    logic [NSECT-1:0] dirty_q, dirty_d;
    logic             download_q, load_req_q, save_req_q;

    logic             dl_rise, dl_fall, ld_rise, sv_rise, as_rise;
    logic             trig_ok, start_load, start_save, save_issue, last_sect;
    logic [SECT_W:0]  nsec, hit, cursor_nx;

    assign nsec      = clip_nsec(img_size);
    assign hit       = find_dirty(dirty_q, cursor_q);
    assign cursor_nx = {1'b0, cursor_q} + ONE;

    assign dl_rise = download & ~download_q;
    assign dl_fall = ~download & download_q;
    assign ld_rise = load_req & ~load_req_q;
    assign sv_rise = save_req & ~save_req_q;

`ifdef NVRAM_AUTOSAVE_EN
    logic as_q, as_cond;
    assign as_cond = pending & osd_open & autosave & ena_q;
    assign as_rise = as_cond & ~as_q;

    always_ff @(posedge clk_sys) begin
        if (reset)
            as_q <= 1'b0;
        else
            as_q <= as_cond;
    end
`else
    logic unused_autosave;
    assign as_rise         = 1'b0;
    assign unused_autosave = &{1'b0, autosave, osd_open};
`endif

    logic unused_addr;
    assign unused_addr = &{1'b0, nv_addr[8:0]};

    // Triggers are only honoured while idle; edges seen while busy are lost.
    assign trig_ok    = (state_q == IDLE) & ena_q;
    assign start_load = trig_ok & (ld_rise | (dl_fall & (img_size != 64'd0)));
    assign start_save = trig_ok & ~start_load & (sv_rise | as_rise);
    assign save_issue = (state_q == SCAN) & ~loading_q & hit[SECT_W] & ~sd_ack;
    assign last_sect  = loading_q ? (cursor_nx >= nsec) : (cursor_q == '1);

    // A core write wins over any clear in the same cycle.
    always_comb begin
        dirty_d = dirty_q;
        if (start_load)
            dirty_d = '0;
        if (save_issue)
            dirty_d[hit[SECT_W-1:0]] = 1'b0;
        if (nv_we)
            dirty_d[nv_addr[SECT_W+8:9]] = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            cursor_q   <= '0;
            lba_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ena_q      <= 1'b0;
            loading_q  <= 1'b0;
            ack_seen_q <= 1'b0;
            dirty_q    <= '0;
            download_q <= 1'b0;
            load_req_q <= 1'b0;
            save_req_q <= 1'b0;
        end else begin
            download_q <= download;
            load_req_q <= load_req;
            save_req_q <= save_req;
            dirty_q    <= dirty_d;

            if (dl_rise)
                ena_q <= 1'b0;
            if (download & img_mounted)
                ena_q <= ~img_readonly;

            case (state_q)
                IDLE: begin
                    if (start_load) begin
                        loading_q <= 1'b1;
                        cursor_q  <= '0;
                        state_q   <= SCAN;
                    end else if (start_save) begin
                        loading_q <= 1'b0;
                        cursor_q  <= '0;
                        state_q   <= SCAN;
                    end
                end
                // A new request is held back until the previous ack has dropped.
                SCAN: begin
                    if (loading_q) begin
                        if ({1'b0, cursor_q} >= nsec) begin
                            loading_q <= 1'b0;
                            state_q   <= IDLE;
                        end else if (!sd_ack) begin
                            lba_q      <= cursor_q;
                            rd_q       <= 1'b1;
                            ack_seen_q <= 1'b0;
                            state_q    <= REQ;
                        end
                    end else begin
                        if (!hit[SECT_W]) begin
                            state_q <= IDLE;
                        end else if (!sd_ack) begin
                            lba_q      <= hit[SECT_W-1:0];
                            cursor_q   <= hit[SECT_W-1:0];
                            wr_q       <= 1'b1;
                            ack_seen_q <= 1'b0;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        rd_q       <= 1'b0;
                        wr_q       <= 1'b0;
                        ack_seen_q <= 1'b1;
                    end
                    state_q <= ACKH;
                end
                ACKH: begin
                    if (sd_ack) begin
                        rd_q       <= 1'b0;
                        wr_q       <= 1'b0;
                        ack_seen_q <= 1'b1;
                    end else if (ack_seen_q) begin
                        if (last_sect) begin
                            loading_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            cursor_q <= cursor_nx[SECT_W-1:0];
                            state_q  <= SCAN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_lba  = {{(LBA_W-SECT_W){1'b0}}, lba_q};
    assign sd_rd   = rd_q;
    assign sd_wr   = wr_q;
    assign ena     = ena_q;
    assign busy    = (state_q != IDLE);
    assign loading = loading_q;
    assign pending = (|dirty_q) & ena_q;

endmodule

// File: tb/tb_nvram_sd_sync.sv
// Directed-plus-random bench for nvram_sd_sync with an sd_ack responder and a
// sector-list reference model of what each load/save must transfer.
`timescale 1ns/1ps
module tb_nvram_sd_sync;
    localparam int SECT_W = 6;
    localparam int LBA_W  = 32;
    localparam int NSECT  = 64;

    logic              clk_sys = 1'b0;
    logic              reset, download, img_mounted, img_readonly;
    logic [63:0]       img_size;
    logic              load_req, save_req, osd_open, autosave, nv_we;
    logic [SECT_W+8:0] nv_addr;
    logic              sd_ack, resp_ack, man_ack;
    logic [LBA_W-1:0]  sd_lba;
    logic              sd_rd, sd_wr, ena, busy, loading, pending;

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    logic              resp_en;
    logic [NSECT-1:0]  m_dirty;
    logic              m_ena;
    logic [1:0]        log_kind[$];
    logic [31:0]       log_lba[$];
    logic [1:0]        exp_kind[$];
    logic [31:0]       exp_lba[$];

    always #5 clk_sys = ~clk_sys;
    assign sd_ack = resp_ack | man_ack;

    nvram_sd_sync #(.SECT_W(SECT_W), .LBA_W(LBA_W)) dut (
        .clk_sys(clk_sys), .reset(reset), .download(download),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .load_req(load_req), .save_req(save_req), .osd_open(osd_open),
        .autosave(autosave), .nv_we(nv_we), .nv_addr(nv_addr), .sd_ack(sd_ack),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .ena(ena), .busy(busy),
        .loading(loading), .pending(pending)
    );

    // hps_io stand-in: logs each request, then acks it after a random delay.
    initial begin
        resp_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (resp_en && (sd_rd || sd_wr)) begin
                log_kind.push_back({sd_rd, sd_wr});
                log_lba.push_back(sd_lba);
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                resp_ack = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk_sys);
                resp_ack = 1'b0;
            end
        end
    end

    always @(negedge clk_sys) if (sd_rd && sd_wr) viol++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic int m_nsec(input longint unsigned size);
        longint unsigned n;
        n = (size + 511) / 512;
        return (n > NSECT) ? NSECT : int'(n);
    endfunction

    task automatic exp_load(input int n);
        exp_kind.delete(); exp_lba.delete();
        for (int i = 0; i < n; i++) begin
            exp_kind.push_back(2'b10);
            exp_lba.push_back(32'(i));
        end
        m_dirty = '0;
    endtask

    task automatic exp_save();
        exp_kind.delete(); exp_lba.delete();
        for (int i = 0; i < NSECT; i++) begin
            if (m_dirty[i]) begin
                exp_kind.push_back(2'b01);
                exp_lba.push_back(32'(i));
            end
        end
        m_dirty = '0;
    endtask

    task automatic write_nv(input logic [SECT_W+8:0] a);
        nv_we = 1'b1; nv_addr = a;
        tick(1);
        nv_we = 1'b0;
        m_dirty[a[SECT_W+8:9]] = 1'b1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1; tick(1); load_req = 1'b0;
    endtask

    task automatic pulse_save();
        save_req = 1'b1; tick(1); save_req = 1'b0;
    endtask

    task automatic mount(input logic [63:0] size, input logic ro);
        download = 1'b1;
        tick(2);
        img_size = size; img_readonly = ro; img_mounted = 1'b1;
        tick(1);
        img_mounted = 1'b0;
        tick(1);
        m_ena = ~ro;
    endtask

    task automatic wait_done(input string tag, input logic exp_ld, input int budget);
        int  n;
        logic bad;
        n = 0; bad = 1'b0;
        tick(1);
        while (busy && n < budget) begin
            if (loading !== exp_ld) bad = 1'b1;
            tick(1);
            n++;
        end
        check({tag, " idle"}, busy, 1'b0);
        check({tag, " loading flag"}, bad, 1'b0);
    endtask

    task automatic compare_logs(input string tag);
        check({tag, " count"}, log_lba.size(), exp_lba.size());
        for (int i = 0; i < exp_lba.size() && i < log_lba.size(); i++) begin
            check($sformatf("%s kind[%0d]", tag, i), log_kind[i], exp_kind[i]);
            check($sformatf("%s lba[%0d]", tag, i), log_lba[i], exp_lba[i]);
        end
        log_kind.delete(); log_lba.delete();
    endtask

    task automatic check_pending(input string tag);
        check({tag, " pending"}, pending, (|m_dirty) & m_ena);
    endtask

    initial begin
        logic [SECT_W+8:0] a;
        logic              found;
        logic              no_rd;
        int                n;

        reset = 1'b1; download = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
        img_size = '0; load_req = 1'b0; save_req = 1'b0; osd_open = 1'b0;
        autosave = 1'b0; nv_we = 1'b0; nv_addr = '0; man_ack = 1'b0;
        resp_en = 1'b1; m_dirty = '0; m_ena = 1'b0;
        tick(3);
        check("rst sd_rd", sd_rd, 1'b0);
        check("rst sd_wr", sd_wr, 1'b0);
        check("rst sd_lba", sd_lba, 32'd0);
        check("rst ena", ena, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst loading", loading, 1'b0);
        check("rst pending", pending, 1'b0);
        reset = 1'b0;
        tick(2);

        // Full 32 KiB image loaded when download drops.
        mount(64'd32768, 1'b0);
        check("mount ena", ena, 1'b1);
        exp_load(m_nsec(32768));
        download = 1'b0;
        wait_done("load32k", 1'b1, 3000);
        compare_logs("load32k");

        // Clipped loads, including a zero-size image and an oversize one.
        img_size = 64'd1536;
        exp_load(m_nsec(1536));
        pulse_load();
        wait_done("load1536", 1'b1, 500);
        compare_logs("load1536");
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: img_size = 64'd0;
                1: img_size = 64'd33000;
                default: img_size = 64'($urandom_range(1, 40000));
            endcase
            exp_load(m_nsec(img_size));
            pulse_load();
            wait_done($sformatf("rload%0d", k), 1'b1, 3000);
            compare_logs($sformatf("rload%0d", k));
        end
        img_size = 64'd32768;

        // Only dirty sectors are written back.
        write_nv(15'h0000); write_nv(15'h0400); write_nv(15'h7FFF);
        check_pending("dirty3");
        exp_save();
        pulse_save();
        wait_done("save3", 1'b0, 500);
        compare_logs("save3");
        check_pending("save3");

        for (int k = 0; k < 2; k++) begin
            n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++) begin
                a = 15'($urandom);
                write_nv(a);
            end
            exp_save();
            pulse_save();
            wait_done($sformatf("rsave%0d", k), 1'b0, 1000);
            compare_logs($sformatf("rsave%0d", k));
        end

        // A write to the sector being saved must survive for the next save.
        write_nv(15'h0000); write_nv(15'h0400); write_nv(15'h1234);
        exp_save();
        pulse_save();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (sd_wr && sd_lba == 32'd2) found = 1'b1;
            else tick(1);
        end
        check("redirty found lba2", found, 1'b1);
        tick(1);
        write_nv(15'h0401);
        wait_done("redirty1", 1'b0, 500);
        compare_logs("redirty1");
        check_pending("redirty1");
        exp_save();
        pulse_save();
        wait_done("redirty2", 1'b0, 500);
        compare_logs("redirty2");
        check_pending("redirty2");

        // Simultaneous load and save: load wins, save edge is dropped.
        write_nv(15'h0A00);
        exp_load(m_nsec(32768));
        load_req = 1'b1; save_req = 1'b1;
        tick(1);
        wait_done("ldsv", 1'b1, 3000);
        compare_logs("ldsv");
        check_pending("ldsv");
        tick(10);
        check("ldsv lost save", log_lba.size(), 0);
        load_req = 1'b0; save_req = 1'b0;
        tick(2);

        // Autosave on OSD open.
        autosave = 1'b1;
        write_nv(15'h2345);
        tick(2);
`ifdef NVRAM_AUTOSAVE_EN
        exp_save();
`else
        exp_kind.delete(); exp_lba.delete();
`endif
        osd_open = 1'b1;
        wait_done("autosave", 1'b0, 500);
        tick(5);
        compare_logs("autosave");
        check_pending("autosave");
        osd_open = 1'b0; autosave = 1'b0;
        tick(2);
        exp_save();
        pulse_save();
        wait_done("flush", 1'b0, 500);
        compare_logs("flush");

        // Reset in the middle of a save with sd_ack stuck high.
        resp_en = 1'b0;
        write_nv(15'h0000); write_nv(15'h0600); write_nv(15'h7000);
        pulse_save();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (sd_wr) found = 1'b1;
            else tick(1);
        end
        check("rstmid found wr", found, 1'b1);
        reset = 1'b1; man_ack = 1'b1;
        tick(1);
        check("rstmid sd_wr", sd_wr, 1'b0);
        check("rstmid busy", busy, 1'b0);
        check("rstmid ena", ena, 1'b0);
        reset = 1'b0;
        m_dirty = '0; m_ena = 1'b0;
        check_pending("rstmid");
        mount(64'd1024, 1'b0);
        download = 1'b0;
        tick(1);
        no_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (sd_rd) no_rd = 1'b0;
            tick(1);
        end
        check("rstmid held busy", busy, 1'b1);
        check("rstmid no rd while ack", no_rd, 1'b1);
        exp_load(m_nsec(1024));
        resp_en = 1'b1; man_ack = 1'b0;
        wait_done("rstmid load", 1'b1, 500);
        compare_logs("rstmid load");

        // Read-only image never binds.
        mount(64'd32768, 1'b1);
        check("ro ena", ena, 1'b0);
        download = 1'b0;
        tick(3);
        pulse_load();
        tick(2);
        write_nv(15'h0200);
        pulse_save();
        tick(20);
        check("ro transfers", log_lba.size(), 0);
        check("ro busy", busy, 1'b0);
        check_pending("ro");

        check("rd/wr overlap", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
